// File: rtl/sd_card_cmd_responder.sv
`default_nettype none
// ============================================================================
// Module      : sd_card_cmd_responder
// Description : Card-side SD CMD-line endpoint. Receives 48-bit host commands
//               on cmd_pin_in, validates transmission/end bits and CRC7,
//               reports good commands, then (optionally) returns an R1, R2
//               or R3 response on cmd_pin_out after NCR cycles.
// Ports       : clock       - sole clock, one CMD bit per rising edge
//               reset       - synchronous, active-high
//               cmd_pin_in  - host-driven CMD line (idles high)
//               cmd_pin_out - card-driven CMD bit (1 when not driving)
//               cmd_oe      - high while cmd_pin_out drives the line
//               cmd_valid   - one-cycle pulse, good command received
//               cmd_index   - index of the last good command
//               cmd_arg     - argument of the last good command
//               rsp_type    - 00 none, 01 R1, 10 R2, 11 R3 (sampled on cmd_valid)
//               rsp_data    - response payload (sampled on cmd_valid)
//               crc_err     - one-cycle pulse, command CRC7 mismatch
//               frame_err   - one-cycle pulse, transmission/end bit wrong
//               busy        - high in every state except IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module sd_card_cmd_responder #(
    parameter int NCR = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         cmd_pin_in,
    output logic         cmd_pin_out,
    output logic         cmd_oe,
    output logic         cmd_valid,
    output logic [5:0]   cmd_index,
    output logic [31:0]  cmd_arg,
    input  logic [1:0]   rsp_type,
    input  logic [127:0] rsp_data,
    output logic         crc_err,
    output logic         frame_err,
    output logic         busy
);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_RX    = 3'd1;
    localparam logic [2:0] c_ST_CHECK = 3'd2;
    localparam logic [2:0] c_ST_WAIT  = 3'd3;
    localparam logic [2:0] c_ST_TX    = 3'd4;

    localparam int c_WAIT_W = (NCR > 2) ? $clog2(NCR) : 1;
    // CHECK is cycle t, WAIT spans t+1..t+NCR-1, TX starts at t+NCR.
    localparam logic [c_WAIT_W-1:0] c_WAIT_LOAD = c_WAIT_W'(NCR - 2);

    localparam logic [7:0] c_RX_LAST_IDX = 8'd46;
    localparam logic [7:0] c_TX_R1_IDX   = 8'd47;
    localparam logic [7:0] c_TX_R2_IDX   = 8'd135;
    localparam logic [7:0] c_CRC_LO_IDX  = 8'd8;
    localparam logic [7:0] c_R2_HDR_IDX  = 8'd127;

    logic [2:0]          r_state;
    logic [2:0]          w_state_nxt;
    logic [7:0]          r_bit_cnt;     // frame bit index currently on the line
    logic [45:0]         r_rx_shift;    // received frame bits [46:1]
    logic [6:0]          r_rx_crc;
    logic                r_cmd_valid;
    logic                r_crc_err;
    logic                r_frame_err;
    logic [5:0]          r_cmd_index;
    logic [31:0]         r_cmd_arg;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic [127:0]        r_tx_shift;    // header + payload, MSB first
    logic [6:0]          r_tx_crc;
    logic                r_tx_r2;
    logic                r_tx_r3;
    logic                w_tx_bit;
    logic                w_rx_frame_bad;
    logic                w_rx_crc_bad;

    function automatic logic [6:0] f_crc7_next(input logic [6:0] crc, input logic din);
        logic fb;
        fb = crc[6] ^ din;
        return {crc[5:0], fb} ^ {3'b000, fb, 3'b000};
    endfunction

    // Evaluated in the final RX cycle: bit 46 sits in r_rx_shift[45], the
    // received CRC field [7:1] in r_rx_shift[6:0], the end bit is on the pin.
    assign w_rx_frame_bad = ~r_rx_shift[45] | ~cmd_pin_in;
    assign w_rx_crc_bad   = (r_rx_shift[6:0] != r_rx_crc);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (!cmd_pin_in) w_state_nxt = c_ST_RX;
            c_ST_RX:    if (r_bit_cnt == 8'd0) w_state_nxt = c_ST_CHECK;
            c_ST_CHECK: begin
                if (r_cmd_valid && (rsp_type != 2'b00)) w_state_nxt = c_ST_WAIT;
                else                                    w_state_nxt = c_ST_IDLE;
            end
            c_ST_WAIT:  if (r_wait_cnt == '0) w_state_nxt = c_ST_TX;
            c_ST_TX:    if (r_bit_cnt == 8'd0) w_state_nxt = c_ST_IDLE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        if (r_bit_cnt >= c_CRC_LO_IDX)  w_tx_bit = r_tx_shift[127];
        else if (r_bit_cnt != 8'd0)     w_tx_bit = r_tx_r3 | r_tx_crc[6]; // R3 CRC field is all ones
        else                            w_tx_bit = 1'b1;                  // end bit

        cmd_oe      = (r_state == c_ST_TX);
        cmd_pin_out = (r_state == c_ST_TX) ? w_tx_bit : 1'b1;
        busy        = (r_state != c_ST_IDLE);
    end

    assign cmd_valid = r_cmd_valid;
    assign crc_err   = r_crc_err;
    assign frame_err = r_frame_err;
    assign cmd_index = r_cmd_index;
    assign cmd_arg   = r_cmd_arg;

    // ------------------------------------------------------------------
    // Datapath: receive shifter, CRC engines, result pulses, TX shifter
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_bit_cnt   <= '0;
            r_rx_shift  <= '0;
            r_rx_crc    <= '0;
            r_cmd_valid <= 1'b0;
            r_crc_err   <= 1'b0;
            r_frame_err <= 1'b0;
            r_cmd_index <= '0;
            r_cmd_arg   <= '0;
            r_wait_cnt  <= '0;
            r_tx_shift  <= '0;
            r_tx_crc    <= '0;
            r_tx_r2     <= 1'b0;
            r_tx_r3     <= 1'b0;
        end else begin
            r_cmd_valid <= 1'b0;
            r_crc_err   <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (!cmd_pin_in) begin
                        // Start bit (frame bit 47) is 0, so with a zero seed it
                        // leaves the CRC unchanged and need not be shifted in.
                        r_rx_shift <= '0;
                        r_rx_crc   <= '0;
                        r_bit_cnt  <= c_RX_LAST_IDX;
                    end
                end
                c_ST_RX: begin
                    r_rx_shift <= {r_rx_shift[44:0], cmd_pin_in};
                    if (r_bit_cnt >= c_CRC_LO_IDX) begin
                        r_rx_crc <= f_crc7_next(r_rx_crc, cmd_pin_in);
                    end
                    if (r_bit_cnt == 8'd0) begin
                        // Results are registered so the pulses and the new
                        // index/argument all appear together in CHECK.
                        if (w_rx_frame_bad) begin
                            r_frame_err <= 1'b1;
                        end else if (w_rx_crc_bad) begin
                            r_crc_err <= 1'b1;
                        end else begin
                            r_cmd_valid <= 1'b1;
                            r_cmd_index <= r_rx_shift[44:39];
                            r_cmd_arg   <= r_rx_shift[38:7];
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt - 8'd1;
                    end
                end
                c_ST_CHECK: begin
                    if (r_cmd_valid && (rsp_type != 2'b00)) begin
                        r_wait_cnt <= c_WAIT_LOAD;
                        r_tx_crc   <= '0;
                        r_tx_r2    <= (rsp_type == 2'b10);
                        r_tx_r3    <= (rsp_type == 2'b11);
                        if (rsp_type == 2'b10) begin
                            r_tx_shift <= {8'h3F, rsp_data[127:8]};
                            r_bit_cnt  <= c_TX_R2_IDX;
                        end else begin
                            r_tx_shift <= {2'b00,
                                           (rsp_type == 2'b11) ? 6'h3F : r_cmd_index,
                                           rsp_data[31:0], 88'd0};
                            r_bit_cnt  <= c_TX_R1_IDX;
                        end
                    end
                end
                c_ST_WAIT: begin
                    r_wait_cnt <= r_wait_cnt - 1'b1;
                end
                c_ST_TX: begin
                    if (r_bit_cnt >= c_CRC_LO_IDX) begin
                        r_tx_shift <= {r_tx_shift[126:0], 1'b0};
                        // R2 CRC excludes its 8-bit header.
                        if (!r_tx_r2 || (r_bit_cnt <= c_R2_HDR_IDX)) begin
                            r_tx_crc <= f_crc7_next(r_tx_crc, r_tx_shift[127]);
                        end
                    end else if (r_bit_cnt != 8'd0) begin
                        r_tx_crc <= {r_tx_crc[5:0], 1'b0};
                    end
                    if (r_bit_cnt != 8'd0) begin
                        r_bit_cnt <= r_bit_cnt - 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sd_card_cmd_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_sd_card_cmd_responder
// Description : Scoreboard bench for sd_card_cmd_responder. Stimulus pushes
//               expected pulses and response bitstreams into queues; a
//               negedge monitor pops and compares them as the DUT produces
//               them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sd_card_cmd_responder;

    localparam int NCR = 2;

    logic         clock;
    logic         reset;
    logic         cmd_pin_in;
    logic         cmd_pin_out;
    logic         cmd_oe;
    logic         cmd_valid;
    logic [5:0]   cmd_index;
    logic [31:0]  cmd_arg;
    logic [1:0]   rsp_type;
    logic [127:0] rsp_data;
    logic         crc_err;
    logic         frame_err;
    logic         busy;

    sd_card_cmd_responder #(.NCR(NCR)) dut (
        .clock       (clock),
        .reset       (reset),
        .cmd_pin_in  (cmd_pin_in),
        .cmd_pin_out (cmd_pin_out),
        .cmd_oe      (cmd_oe),
        .cmd_valid   (cmd_valid),
        .cmd_index   (cmd_index),
        .cmd_arg     (cmd_arg),
        .rsp_type    (rsp_type),
        .rsp_data    (rsp_data),
        .crc_err     (crc_err),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // kind: 0 cmd_valid, 1 crc_err, 2 frame_err
    typedef struct packed {
        logic [1:0]  kind;
        logic [5:0]  idx;
        logic [31:0] arg;
    } ev_t;

    typedef struct packed {
        logic [31:0]  nbits;
        logic [135:0] bits;
    } rsp_t;

    ev_t  ev_q[$];
    rsp_t rsp_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t_valid = -1000;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] crc7(input logic [135:0] d, input int n);
        logic [6:0] c;
        logic       fb;
        c = 7'd0;
        for (int i = n - 1; i >= 0; i--) begin
            fb = c[6] ^ d[i];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    ev_t          m_ev;
    rsp_t         m_rsp;
    logic         cap_on = 1'b0;
    logic [135:0] cap;
    int           cap_n;

    always @(negedge clock) begin
        if (cmd_valid || crc_err || frame_err) begin
            check("pulse_onehot", 136'(cmd_valid) + 136'(crc_err) + 136'(frame_err), 136'd1);
            if (ev_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse: got valid=%0b crc=%0b frame=%0b expected none",
                         cmd_valid, crc_err, frame_err);
            end else begin
                m_ev = ev_q.pop_front();
                check("pulse_kind", cmd_valid ? 136'd0 : (crc_err ? 136'd1 : 136'd2), 136'(m_ev.kind));
                check("cmd_index", 136'(cmd_index), 136'(m_ev.idx));
                check("cmd_arg", 136'(cmd_arg), 136'(m_ev.arg));
            end
            if (cmd_valid) t_valid = cyc;
        end

        if (!cmd_oe) check("pin_high_when_not_driven", 136'(cmd_pin_out), 136'd1);

        if (cmd_oe && !cap_on) begin
            cap_on = 1'b1;
            cap    = '0;
            cap_n  = 0;
            check("rsp_start_cycle", 136'(cyc), 136'(t_valid + NCR));
        end
        if (cmd_oe) begin
            cap   = {cap[134:0], cmd_pin_out};
            cap_n = cap_n + 1;
        end else if (cap_on) begin
            cap_on = 1'b0;
            if (rsp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_response: got %0d bits expected none", cap_n);
            end else begin
                m_rsp = rsp_q.pop_front();
                check("rsp_length", 136'(cap_n), 136'(m_rsp.nbits));
                check("rsp_bits", cap, m_rsp.bits);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic push_ev(input logic [1:0] k, input logic [5:0] i, input logic [31:0] a);
        ev_t e;
        e.kind = k;
        e.idx  = i;
        e.arg  = a;
        ev_q.push_back(e);
    endtask

    task automatic push_rsp(input int n, input logic [135:0] b);
        rsp_t r;
        r.nbits = 32'(n);
        r.bits  = b;
        rsp_q.push_back(r);
    endtask

    // Returns at the negedge of the CHECK cycle.
    task automatic send_frame(input logic [47:0] f);
        for (int i = 47; i >= 0; i--) begin
            @(negedge clock);
            cmd_pin_in = f[i];
        end
        @(negedge clock);
        cmd_pin_in = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 400) begin
            @(negedge clock);
            n++;
        end
        check(name, 136'(busy), 136'd0);
        repeat (3) @(negedge clock);
    endtask

    logic [47:0]  f2;
    logic [47:0]  f41;
    logic [127:0] d2;
    logic [135:0] r2_exp;
    logic [47:0]  r1_full;
    int           n;

    initial begin
        reset      = 1'b1;
        cmd_pin_in = 1'b1;
        rsp_type   = 2'b00;
        rsp_data   = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst_cmd_oe", 136'(cmd_oe), 136'd0);
        check("rst_pin_out", 136'(cmd_pin_out), 136'd1);
        check("rst_busy", 136'(busy), 136'd0);
        check("rst_cmd_index", 136'(cmd_index), 136'd0);
        check("rst_cmd_arg", 136'(cmd_arg), 136'd0);
        check("rst_pulses", {133'd0, cmd_valid, crc_err, frame_err}, 136'd0);
        repeat (2) @(negedge clock);

        // CMD0, no response
        push_ev(2'd0, 6'd0, 32'd0);
        send_frame(48'h400000000095);
        check("cmd0_busy_in_check", 136'(busy), 136'd1);
        @(negedge clock);
        check("cmd0_busy_after_check", 136'(busy), 136'd0);
        check("cmd0_oe", 136'(cmd_oe), 136'd0);
        wait_idle("cmd0_idle");

        // CMD8, R1
        rsp_type = 2'b01;
        rsp_data = 128'h000001AA;
        push_ev(2'd0, 6'd8, 32'h000001AA);
        push_rsp(48, 136'(48'h08000001AA13));
        send_frame(48'h48000001AA87);
        wait_idle("cmd8_idle");

        // CMD17 with CRC bit 1 flipped; response type left set to R1
        push_ev(2'd1, 6'd8, 32'h000001AA);
        send_frame(48'h510000000057);
        wait_idle("cmd17_idle");

        // CMD55 with end bit 0, then CMD0
        push_ev(2'd2, 6'd8, 32'h000001AA);
        send_frame(48'h770000000064);
        wait_idle("cmd55_idle");
        rsp_type = 2'b00;
        push_ev(2'd0, 6'd0, 32'd0);
        send_frame(48'h400000000095);
        wait_idle("cmd0b_idle");

        // CMD2, R2
        d2       = 128'h0123456789ABCDEF0011223344556677;
        rsp_type = 2'b10;
        rsp_data = d2;
        f2       = {40'h4200000000, crc7(136'(40'h4200000000), 40), 1'b1};
        r2_exp   = {8'h3F, d2[127:8], crc7(136'(d2[127:8]), 120), 1'b1};
        push_ev(2'd0, 6'd2, 32'd0);
        push_rsp(136, r2_exp);
        send_frame(f2);
        wait_idle("cmd2_idle");

        // ACMD41, R3
        rsp_type = 2'b11;
        rsp_data = 128'h80FF8000;
        f41      = {40'h6940300000, crc7(136'(40'h6940300000), 40), 1'b1};
        push_ev(2'd0, 6'd41, 32'h40300000);
        push_rsp(48, 136'({2'b00, 6'h3F, 32'h80FF8000, 7'h7F, 1'b1}));
        send_frame(f41);
        wait_idle("cmd41_idle");

        // CMD8 again, reset while response bit 20 is on the line
        rsp_type = 2'b01;
        rsp_data = 128'h000001AA;
        r1_full  = 48'h08000001AA13;
        push_ev(2'd0, 6'd8, 32'h000001AA);
        push_rsp(21, 136'(r1_full >> 27));
        send_frame(48'h48000001AA87);
        n = 0;
        while (!cmd_oe && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("abort_rsp_started", 136'(cmd_oe), 136'd1);
        repeat (20) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("abort_cmd_oe", 136'(cmd_oe), 136'd0);
        check("abort_busy", 136'(busy), 136'd0);
        check("abort_index_cleared", 136'(cmd_index), 136'd0);
        reset    = 1'b0;
        rsp_type = 2'b00;
        push_ev(2'd0, 6'd0, 32'd0);
        send_frame(48'h400000000095);
        wait_idle("cmd0c_idle");

        repeat (5) @(negedge clock);
        check("events_left", 136'(ev_q.size()), 136'd0);
        check("responses_left", 136'(rsp_q.size()), 136'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
